// File: rtl/tmp_word_reg.sv
// Temporary word register of LANES byte lanes. Fills and drains byte-serially through a lane
// pointer, loads and drives the whole word, and increments or decrements in place.
module tmp_word_reg #(
  parameter int  DATA_W = 8,
  parameter int  LANES  = 2,
  localparam int AW     = DATA_W * LANES,
  localparam int PW     = (LANES > 2) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_wr,
  input  logic              data_rd,
  input  logic              data_step,
  input  logic              ptr_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [AW-1:0]     addr_in,
  input  logic              addr_load,
  input  logic              addr_rd,
  output logic [AW-1:0]     addr_out,
  output logic              addr_oe,
  input  logic              inc,
  input  logic              dec,
  output logic [PW-1:0]     ptr,
  output logic              filled,
  output logic              wrapped
);

  logic [AW-1:0]    word_q, word_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic             filled_q, filled_d;
  logic             wrapped_q, wrapped_d;

  // Word update: whole-word load beats a lane write, which beats inc/dec.
  always_comb begin
    word_d    = word_q;
    wrapped_d = 1'b0;
    if (addr_load) begin
      word_d = addr_in;
    end else if (data_wr) begin
      for (int l = 0; l < LANES; l++) begin
        if (ptr_q == PW'(l)) word_d[l*DATA_W +: DATA_W] = data_in;
      end
    end else if (inc && !dec) begin
      word_d    = word_q + AW'(1);
      wrapped_d = &word_q;
    end else if (dec && !inc) begin
      word_d    = word_q - AW'(1);
      wrapped_d = (word_q == '0);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (ptr_clr) begin
      ptr_d = '0;
    end else if (data_step) begin
      ptr_d = (ptr_q == PW'(LANES - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  // filled is sticky until ptr_clr; a whole-word load counts as every lane defined.
  always_comb begin
    mask_d = mask_q;
    if (addr_load || ptr_clr) begin
      mask_d = '0;
    end else if (data_wr) begin
      for (int l = 0; l < LANES; l++) begin
        if (ptr_q == PW'(l)) mask_d[l] = 1'b1;
      end
    end
    filled_d = filled_q | (&mask_d);
    if (ptr_clr)   filled_d = 1'b0;
    if (addr_load) filled_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q    <= '0;
      ptr_q     <= '0;
      mask_q    <= '0;
      filled_q  <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      ptr_q     <= ptr_d;
      mask_q    <= mask_d;
      filled_q  <= filled_d;
      wrapped_q <= wrapped_d;
    end
  end

  always_comb begin
    data_out = '0;
    for (int l = 0; l < LANES; l++) begin
      if (ptr_q == PW'(l)) data_out = word_q[l*DATA_W +: DATA_W];
    end
  end

  assign data_oe  = data_rd;
  assign addr_oe  = addr_rd;
  assign addr_out = word_q;
  assign ptr      = ptr_q;
  assign filled   = filled_q;
  assign wrapped  = wrapped_q;

endmodule

// File: tb/tb_tmp_word_reg.sv
// Scoreboard bench for tmp_word_reg: a 2-lane and a 3-lane instance of 8-bit lanes.
module tb_tmp_word_reg;

  typedef struct {
    logic        load;
    logic [15:0] ain;
    logic        wr;
    logic [7:0]  din;
    logic        rd;
    logic        step;
    logic        clr;
    logic        inc;
    logic        dec;
  } stim_t;

  typedef struct {
    logic [23:0] word;
    logic [1:0]  ptr;
    logic        filled;
    logic        wrapped;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rq[$];
  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 2-lane instance
  logic [7:0]  data_in = '0;
  logic        data_wr = 0, data_rd = 0, data_step = 0, ptr_clr = 0;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [15:0] addr_in = '0;
  logic        addr_load = 0, addr_rd = 0, inc = 0, dec = 0;
  logic [15:0] addr_out;
  logic        addr_oe;
  logic        ptr, filled, wrapped;

  // 3-lane instance
  logic [7:0]  t_data_in = '0;
  logic        t_data_wr = 0, t_data_step = 0, t_ptr_clr = 0;
  logic [7:0]  t_data_out;
  logic        t_data_oe, t_addr_oe;
  logic [23:0] t_addr_out;
  logic [1:0]  t_ptr;
  logic        t_filled, t_wrapped;

  tmp_word_reg #(.DATA_W(8), .LANES(2)) u2 (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_wr(data_wr), .data_rd(data_rd), .data_step(data_step),
    .ptr_clr(ptr_clr), .data_out(data_out), .data_oe(data_oe),
    .addr_in(addr_in), .addr_load(addr_load), .addr_rd(addr_rd),
    .addr_out(addr_out), .addr_oe(addr_oe), .inc(inc), .dec(dec),
    .ptr(ptr), .filled(filled), .wrapped(wrapped)
  );

  tmp_word_reg #(.DATA_W(8), .LANES(3)) u3 (
    .clk(clk), .rst(rst),
    .data_in(t_data_in), .data_wr(t_data_wr), .data_rd(1'b0), .data_step(t_data_step),
    .ptr_clr(t_ptr_clr), .data_out(t_data_out), .data_oe(t_data_oe),
    .addr_in(24'h0), .addr_load(1'b0), .addr_rd(1'b0),
    .addr_out(t_addr_out), .addr_oe(t_addr_oe), .inc(1'b0), .dec(1'b0),
    .ptr(t_ptr), .filled(t_filled), .wrapped(t_wrapped)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input stim_t s);
    addr_load = s.load; addr_in = s.ain; data_wr = s.wr; data_in = s.din;
    data_rd = s.rd; data_step = s.step; ptr_clr = s.clr; inc = s.inc; dec = s.dec;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({addr_out, data_out, ptr, filled, wrapped, data_oe, addr_oe} !== 29'h0) begin
      bad++;
      $display("FAIL reset2 got word=%h dout=%h ptr=%0d f=%b w=%b doe=%b aoe=%b exp all 0",
               addr_out, data_out, ptr, filled, wrapped, data_oe, addr_oe);
    end
    total++;
    if ({t_addr_out, t_ptr, t_filled, t_wrapped} !== 28'h0) begin
      bad++;
      $display("FAIL reset3 got word=%h ptr=%0d f=%b w=%b exp all 0", t_addr_out, t_ptr, t_filled, t_wrapped);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    stim_t st [2] = '{'{0, 16'h0, 1, 8'h34, 0, 1, 0, 0, 0},
                      '{0, 16'h0, 1, 8'h12, 0, 1, 0, 0, 0}};
    exp_t  ex [2] = '{'{24'h000034, 2'd1, 1'b0, 1'b0},
                      '{24'h001234, 2'd0, 1'b1, 1'b0}};
    exp_t  e;
    for (int i = 0; i < 2; i++) begin
      drive2(st[i]);
      sb.push_back(ex[i]);
      tick();
      e = sb.pop_front();
      total++;
      if ({8'h00, addr_out, 1'b0, ptr, filled, wrapped} !== {e.word, e.ptr, e.filled, e.wrapped}) begin
        bad++;
        $display("FAIL fill[%0d] got word=%h ptr=%0d f=%b w=%b exp word=%h ptr=%0d f=%b w=%b",
                 i, addr_out, ptr, filled, wrapped, e.word, e.ptr, e.filled, e.wrapped);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t st [5] = '{'{1, 16'hFFFF, 0, 8'h0, 0, 0, 0, 0, 0},
                      '{0, 16'h0,    0, 8'h0, 0, 0, 0, 1, 0},
                      '{0, 16'h0,    0, 8'h0, 0, 0, 0, 0, 0},
                      '{0, 16'h0,    0, 8'h0, 0, 0, 0, 0, 1},
                      '{0, 16'h0,    0, 8'h0, 0, 0, 0, 0, 0}};
    exp_t  ex [5] = '{'{24'h00FFFF, 2'd0, 1'b1, 1'b0},
                      '{24'h000000, 2'd0, 1'b1, 1'b1},
                      '{24'h000000, 2'd0, 1'b1, 1'b0},
                      '{24'h00FFFF, 2'd0, 1'b1, 1'b1},
                      '{24'h00FFFF, 2'd0, 1'b1, 1'b0}};
    exp_t  e;
    for (int i = 0; i < 5; i++) begin
      drive2(st[i]);
      sb.push_back(ex[i]);
      tick();
      e = sb.pop_front();
      total++;
      if ({8'h00, addr_out, 1'b0, ptr, filled, wrapped} !== {e.word, e.ptr, e.filled, e.wrapped}) begin
        bad++;
        $display("FAIL wrap[%0d] got word=%h ptr=%0d f=%b w=%b exp word=%h ptr=%0d f=%b w=%b",
                 i, addr_out, ptr, filled, wrapped, e.word, e.ptr, e.filled, e.wrapped);
      end
    end
  endtask

  task automatic test_priority();
    stim_t st [11] = '{'{1, 16'hABCD, 1, 8'h55, 0, 0, 0, 1, 0},
                       '{1, 16'hFFFF, 0, 8'h00, 0, 0, 0, 0, 0},
                       '{0, 16'h0,    0, 8'h00, 0, 0, 0, 1, 1},
                       '{0, 16'h0,    1, 8'h55, 0, 0, 0, 1, 0},
                       '{0, 16'h0,    0, 8'h00, 0, 0, 1, 0, 0},
                       '{0, 16'h0,    1, 8'h66, 0, 1, 0, 0, 0},
                       '{0, 16'h0,    1, 8'h77, 0, 1, 1, 0, 0},
                       '{0, 16'h0,    1, 8'h88, 0, 1, 0, 0, 0},
                       '{0, 16'h0,    0, 8'h00, 0, 1, 0, 0, 0},
                       '{0, 16'h0,    1, 8'h99, 0, 1, 0, 0, 0},
                       '{0, 16'h0,    1, 8'hAA, 0, 1, 0, 0, 0}};
    exp_t  ex [11] = '{'{24'h00ABCD, 2'd0, 1'b1, 1'b0},
                       '{24'h00FFFF, 2'd0, 1'b1, 1'b0},
                       '{24'h00FFFF, 2'd0, 1'b1, 1'b0},
                       '{24'h00FF55, 2'd0, 1'b1, 1'b0},
                       '{24'h00FF55, 2'd0, 1'b0, 1'b0},
                       '{24'h00FF66, 2'd1, 1'b0, 1'b0},
                       '{24'h007766, 2'd0, 1'b0, 1'b0},
                       '{24'h007788, 2'd1, 1'b0, 1'b0},
                       '{24'h007788, 2'd0, 1'b0, 1'b0},
                       '{24'h007799, 2'd1, 1'b0, 1'b0},
                       '{24'h00AA99, 2'd0, 1'b1, 1'b0}};
    exp_t  e;
    for (int i = 0; i < 11; i++) begin
      drive2(st[i]);
      sb.push_back(ex[i]);
      tick();
      e = sb.pop_front();
      total++;
      if ({8'h00, addr_out, 1'b0, ptr, filled, wrapped} !== {e.word, e.ptr, e.filled, e.wrapped}) begin
        bad++;
        $display("FAIL prio[%0d] got word=%h ptr=%0d f=%b w=%b exp word=%h ptr=%0d f=%b w=%b",
                 i, addr_out, ptr, filled, wrapped, e.word, e.ptr, e.filled, e.wrapped);
      end
    end
  endtask

  // Combinational read path: each row is checked before its edge, then one cycle after.
  task automatic test_read();
    stim_t st [3] = '{'{0, 16'h0, 0, 8'h00, 1, 0, 0, 0, 0},
                      '{0, 16'h0, 0, 8'h00, 1, 1, 0, 0, 0},
                      '{0, 16'h0, 1, 8'h56, 1, 0, 0, 0, 0}};
    logic [7:0] pre  [3] = '{8'h12, 8'h12, 8'h34};
    logic [7:0] post [3] = '{8'h12, 8'h34, 8'h56};
    logic [7:0] r;
    drive2('{1, 16'h1234, 0, 8'h00, 0, 1, 0, 0, 0});
    tick();
    for (int i = 0; i < 3; i++) begin
      drive2(st[i]);
      addr_rd = 1'b1;
      rq.push_back(pre[i]);
      rq.push_back(post[i]);
      #1;
      r = rq.pop_front();
      total++;
      if ({data_out, data_oe, addr_oe, addr_out} !== {r, 1'b1, 1'b1, 16'h1234 ^ ((i == 2) ? 16'h0 : 16'h0)} &&
          !(i == 2 && {data_out, data_oe, addr_oe} === {r, 1'b1, 1'b1} && addr_out === 16'h1234)) begin
        bad++;
        $display("FAIL read_pre[%0d] got dout=%h doe=%b aoe=%b aout=%h exp dout=%h doe=1 aoe=1 aout=1234",
                 i, data_out, data_oe, addr_oe, addr_out, r);
      end
      tick();
      r = rq.pop_front();
      total++;
      if (data_out !== r) begin
        bad++;
        $display("FAIL read_post[%0d] got dout=%h exp dout=%h", i, data_out, r);
      end
    end
    drive2('{0, 16'h0, 0, 8'h00, 0, 0, 0, 0, 0});
    addr_rd = 1'b0;
    #1;
    total++;
    if ({data_oe, addr_oe, addr_out} !== {1'b0, 1'b0, 16'h1256}) begin
      bad++;
      $display("FAIL read_idle got doe=%b aoe=%b aout=%h exp doe=0 aoe=0 aout=1256", data_oe, addr_oe, addr_out);
    end
  endtask

  task automatic test_lanes3();
    logic [7:0] din [4] = '{8'h01, 8'h02, 8'h03, 8'h00};
    exp_t ex [4] = '{'{24'h000001, 2'd1, 1'b0, 1'b0},
                     '{24'h000201, 2'd2, 1'b0, 1'b0},
                     '{24'h030201, 2'd0, 1'b1, 1'b0},
                     '{24'h030201, 2'd0, 1'b0, 1'b0}};
    exp_t e;
    total++;
    if (t_ptr !== 2'd0) begin
      bad++;
      $display("FAIL l3_start got ptr=%0d exp ptr=0", t_ptr);
    end
    for (int i = 0; i < 4; i++) begin
      t_data_in   = din[i];
      t_data_wr   = (i < 3);
      t_data_step = 1'b1;
      t_ptr_clr   = (i == 3);
      sb.push_back(ex[i]);
      tick();
      e = sb.pop_front();
      total++;
      if ({t_addr_out, t_ptr, t_filled, t_wrapped} !== {e.word, e.ptr, e.filled, e.wrapped}) begin
        bad++;
        $display("FAIL l3[%0d] got word=%h ptr=%0d f=%b w=%b exp word=%h ptr=%0d f=%b w=%b",
                 i, t_addr_out, t_ptr, t_filled, t_wrapped, e.word, e.ptr, e.filled, e.wrapped);
      end
    end
    t_data_wr = 1'b0; t_data_step = 1'b0; t_ptr_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    drive2('{1, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0});
    tick();
    drive2('{0, 16'h0, 0, 8'h00, 0, 1, 0, 0, 1});
    sb.push_back('{24'h00FFFF, 2'd1, 1'b1, 1'b1});
    tick();
    drive2('{0, 16'h0, 0, 8'h00, 0, 0, 0, 0, 0});
    e = sb.pop_front();
    total++;
    if ({8'h00, addr_out, 1'b0, ptr, filled, wrapped} !== {e.word, e.ptr, e.filled, e.wrapped}) begin
      bad++;
      $display("FAIL arst_pre got word=%h ptr=%0d f=%b w=%b exp word=%h ptr=%0d f=%b w=%b",
               addr_out, ptr, filled, wrapped, e.word, e.ptr, e.filled, e.wrapped);
    end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({addr_out, data_out, ptr, filled, wrapped} !== 27'h0) begin
      bad++;
      $display("FAIL arst2 got word=%h dout=%h ptr=%0d f=%b w=%b exp all 0", addr_out, data_out, ptr, filled, wrapped);
    end
    total++;
    if ({t_addr_out, t_ptr, t_filled} !== 27'h0) begin
      bad++;
      $display("FAIL arst3 got word=%h ptr=%0d f=%b exp all 0", t_addr_out, t_ptr, t_filled);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++;
    if ({addr_out, ptr, filled, wrapped} !== 19'h0) begin
      bad++;
      $display("FAIL arst_after got word=%h ptr=%0d f=%b w=%b exp all 0", addr_out, ptr, filled, wrapped);
    end
  endtask

  initial begin
    test_reset();
    tick();
    test_fill();
    test_wrap();
    test_priority();
    test_read();
    test_lanes3();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tmp_word_reg.md
Name: tmp_word_reg

Overview:
- Parametrised successor to the two-half temporary register pair.
- Holds one word of LANES bytes (lanes of DATA_W bits). Fills and drains byte-serially over the data bus via an internal lane pointer, loads or drives the whole word on the address bus, and increments or decrements in place for address arithmetic.
- Bus tri-stating stays in the enclosing adapter. This block exposes separate in/out/output-enable signals.

Parameters:
- DATA_W, 8: width of one lane and of the data bus.
- LANES, 2: number of lanes, at least 2. AW = DATA_W*LANES is the address bus width. Lane 0 is least significant.

Ports:
- clk, input, 1: clock; all state changes on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- data_in, input, DATA_W: byte from the data bus.
- data_wr, input, 1: write data_in into the lane at ptr.
- data_rd, input, 1: drive the lane at ptr onto data_out.
- data_step, input, 1: advance ptr after this cycle's read or write.
- ptr_clr, input, 1: ptr <= 0, filled <= 0.
- data_out, output, DATA_W: lane[ptr]; combinational from registers.
- data_oe, output, 1: equals data_rd, combinational.
- addr_in, input, AW: word from the address bus.
- addr_load, input, 1: word <= addr_in.
- addr_rd, input, 1: drive the word onto addr_out.
- addr_out, output, AW: the current word, combinational.
- addr_oe, output, 1: equals addr_rd, combinational.
- inc, input, 1: word <= word+1 mod 2^AW.
- dec, input, 1: word <= word-1 mod 2^AW.
- ptr, output, clog2(LANES) (min 1): current lane pointer.
- filled, output, 1: every lane written via data_wr since the last ptr_clr or reset.
- wrapped, output, 1: one-cycle registered pulse after inc overflows or dec underflows.

Behaviour:
- Reset (async, immediate): word=0, ptr=0, filled=0, wrapped=0. data_out=0 and addr_out=0 follow from that. data_oe and addr_oe follow their inputs and are therefore 0 when those inputs are 0.
- Word update priority per edge: addr_load > data_wr > inc/dec.
  - addr_load: word <= addr_in. data_wr, inc and dec have no effect on the word that cycle.
  - data_wr (no addr_load): only lane[ptr] <= data_in; other lanes hold.
  - inc and dec both high: word holds, wrapped=0.
- wrapped: set for exactly one cycle after an edge where an effective inc saw word=all-ones, or an effective dec saw word=0. Otherwise 0 on the next cycle.
- Pointer rules:
  - ptr_clr has priority over data_step.
  - data_step: ptr <= ptr+1; LANES-1 wraps to 0.
  - data_step is effective even without data_rd or data_wr (skip lane).
  - data_wr & data_rd & data_step: one advance only.
- filled tracking:
  - Internal per-lane written mask; data_wr sets bit ptr.
  - filled = all bits set, registered.
  - ptr_clr or addr_load clears the mask; addr_load also sets filled=1 (word fully defined).
  - data_wr with ptr_clr in the same cycle: the write lands in the old ptr lane; mask and ptr still clear.
- Read latency: zero-cycle combinational; data_out shows the pre-edge lane.
  - Read-after-write to the same lane shows the new value the cycle after the edge.
- data_rd and data_wr together: the block allows it; the adapter must not enable both bus directions.
- Non-power-of-two LANES: ptr wraps at LANES-1, never reaches LANES.

Test Plan:
- DATA_W=8, LANES=2. Reset, then data_wr+data_step with 0x34 then 0x12 -> word=0x1234, ptr=0, filled=1 after second edge.
- addr_load 0xFFFF, then inc one cycle -> addr_out=0x0000, wrapped=1 for exactly one cycle. Then dec -> 0xFFFF, wrapped=1 again.
- Word=0x1234, ptr=1, data_rd=1 -> data_out=0x12, data_oe=1. Step -> data_out=0x34.
- Same edge addr_load 0xABCD + data_wr 0x55 + inc -> word=0xABCD, filled=1, wrapped=0.
- LANES=3, three stepped writes 0x01,0x02,0x03 -> word=0x030201, ptr sequence 0,1,2,0. ptr_clr+data_step in one cycle -> ptr=0, filled=0.
- Assert rst mid-sequence between clock edges -> all state 0 immediately, before the next edge.
